// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity checker and its generator twin:
// FSM state encodings and the even/odd parity selector constants.
package serial_parity_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial bit-stream in / word-level result out bundle for serial_parity_checker.
// err_cnt exists only when PARITY_CHK_ERR_CNT_EN is defined.
interface serial_parity_checker_if #(
  parameter int DATA_W = 8
);
  logic              bit_in;
  logic              bit_valid;
  logic              sync_clr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              busy;
`ifdef PARITY_CHK_ERR_CNT_EN
  logic [7:0]        err_cnt;

  modport master (
    output bit_in, bit_valid, sync_clr,
    input  data_out, data_valid, parity_err, busy, err_cnt
  );

  modport slave (
    input  bit_in, bit_valid, sync_clr,
    output data_out, data_valid, parity_err, busy, err_cnt
  );
`else
  modport master (
    output bit_in, bit_valid, sync_clr,
    input  data_out, data_valid, parity_err, busy
  );

  modport slave (
    input  bit_in, bit_valid, sync_clr,
    output data_out, data_valid, parity_err, busy
  );
`endif
endinterface

// File: rtl/serial_parity_checker_sat_counter8.sv
// 8-bit counter that increments on inc and sticks at 255; cleared only by rst.
// Registered output, one cycle from inc to updated count; inc is never refused.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] cnt
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises DATA_W data bits (LSB first) plus a parity bit, flags mismatch one cycle after the parity bit.
// No backpressure: every bit_valid bit is accepted; optional error counter under PARITY_CHK_ERR_CNT_EN.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter bit ODD    = PARITY_EVEN
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_parity_checker_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic [DATA_W-1:0] data_reg_q, data_reg_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    data_reg_d   = data_reg_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;

    if (bus.sync_clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = 1'b0;
    end else if (bus.bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          // Bits enter at the MSB and shift down, so the first bit lands at index 0.
          data_reg_d = {bus.bit_in, data_reg_q[DATA_W-1:1]};
          acc_d      = bus.bit_in;
          cnt_d      = CNT_W'(1);
          state_d    = (DATA_W == 1) ? ST_PARITY : ST_DATA;
        end
        ST_DATA: begin
          data_reg_d = {bus.bit_in, data_reg_q[DATA_W-1:1]};
          acc_d      = acc_q ^ bus.bit_in;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          data_out_d   = data_reg_q;
          data_valid_d = 1'b1;
          parity_err_d = acc_q ^ bus.bit_in ^ ODD;
          cnt_d        = '0;
          acc_d        = 1'b0;
          state_d      = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          acc_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      data_reg_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      data_reg_q   <= data_reg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = busy_q;

`ifdef PARITY_CHK_ERR_CNT_EN
  logic [7:0] err_cnt;

  sat_counter8 u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (parity_err_q),
    .cnt (err_cnt)
  );

  assign bus.err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: an even and an odd instance share one stimulus stream.
module tb_serial_parity_checker;
  import serial_parity_checker_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic bit_in    = 1'b0;
  logic bit_valid = 1'b0;
  logic sync_clr  = 1'b0;

  serial_parity_checker_if #(.DATA_W(8)) ev_if ();
  serial_parity_checker_if #(.DATA_W(8)) od_if ();

  assign ev_if.bit_in    = bit_in;
  assign ev_if.bit_valid = bit_valid;
  assign ev_if.sync_clr  = sync_clr;
  assign od_if.bit_in    = bit_in;
  assign od_if.bit_valid = bit_valid;
  assign od_if.sync_clr  = sync_clr;

  serial_parity_checker #(.DATA_W(8), .ODD(PARITY_EVEN)) u_even (
    .clk (clk),
    .rst (rst),
    .bus (ev_if.slave)
  );

  serial_parity_checker #(.DATA_W(8), .ODD(PARITY_ODD)) u_odd (
    .clk (clk),
    .rst (rst),
    .bus (od_if.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pos   = 0;
  logic exp_busy = 1'b0;
  logic chk_busy = 1'b0;

  logic [7:0] got_dat[$];
  logic       got_err[$];
  int         got_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample the even instance at the falling edge, then drive the next bit.
  task automatic tick(input logic b, input logic v, input logic c);
    @(negedge clk);
    cyc++;
    if (ev_if.data_valid) begin
      got_dat.push_back(ev_if.data_out);
      got_err.push_back(ev_if.parity_err);
      got_cyc.push_back(cyc);
    end
    if (chk_busy) check("busy_track", 32'(ev_if.busy), 32'(exp_busy));
    bit_in    = b;
    bit_valid = v;
    sync_clr  = c;
    if (c) begin
      exp_busy = 1'b0;
      pos      = 0;
    end else if (v) begin
      exp_busy = (pos != 8);
      pos      = (pos == 8) ? 0 : pos + 1;
    end
  endtask

  task automatic send_word(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) tick(d[i], 1'b1, 1'b0);
    tick(p, 1'b1, 1'b0);
  endtask

  task automatic clear_q();
    got_dat.delete();
    got_err.delete();
    got_cyc.delete();
  endtask

  logic [17:0] b2b_bits;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data_out", 32'(ev_if.data_out), 32'h0);
    check("rst_data_valid", 32'(ev_if.data_valid), 32'h0);
    check("rst_parity_err", 32'(ev_if.parity_err), 32'h0);
    check("rst_busy", 32'(ev_if.busy), 32'h0);
`ifdef PARITY_CHK_ERR_CNT_EN
    check("rst_err_cnt", 32'(ev_if.err_cnt), 32'h0);
`endif
    rst = 1'b0;
    tick(1'b0, 1'b0, 1'b0);

    // 0xA5 with correct even parity: pulse exactly one cycle after the parity bit
    clear_q();
    send_word(8'hA5, 1'b0);
    check("a5_no_early_dv", 32'(got_dat.size()), 32'd0);
    check("a5_busy_in_parity", 32'(ev_if.busy), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    check("a5_dv_latency", 32'(got_dat.size()), 32'd1);
    check("a5_data_out", 32'(ev_if.data_out), 32'hA5);
    check("a5_parity_err", 32'(ev_if.parity_err), 32'h0);
    check("a5_busy_falls", 32'(ev_if.busy), 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    check("a5_pulse_width", 32'(got_dat.size()), 32'd1);
    check("a5_data_hold", 32'(ev_if.data_out), 32'hA5);

    // 0xA5 with wrong parity: word still delivered, error flagged
    clear_q();
    send_word(8'hA5, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("a5bad_dv", 32'(ev_if.data_valid), 32'h1);
    check("a5bad_data_out", 32'(ev_if.data_out), 32'hA5);
    check("a5bad_parity_err", 32'(ev_if.parity_err), 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    check("a5bad_err_pulse", 32'(ev_if.parity_err), 32'h0);
`ifdef PARITY_CHK_ERR_CNT_EN
    check("a5bad_err_cnt", 32'(ev_if.err_cnt), 32'd1);
`endif

    // Odd-parity instance: 0x01 has one set bit
    send_word(8'h01, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("odd_ok_dv", 32'(od_if.data_valid), 32'h1);
    check("odd_ok_data", 32'(od_if.data_out), 32'h01);
    check("odd_ok_err", 32'(od_if.parity_err), 32'h0);
    send_word(8'h01, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("odd_bad_dv", 32'(od_if.data_valid), 32'h1);
    check("odd_bad_err", 32'(od_if.parity_err), 32'h1);

    // Back-to-back 0x3C then 0xFF, no idle cycles between frames
    clear_q();
    chk_busy = 1'b1;
    b2b_bits = {1'b0, 8'hFF, 1'b0, 8'h3C};
    for (int i = 0; i < 18; i++) tick(b2b_bits[i], 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    check("b2b_pulses", 32'(got_dat.size()), 32'd2);
    if (got_dat.size() == 2) begin
      check("b2b_word0", 32'(got_dat[0]), 32'h3C);
      check("b2b_word1", 32'(got_dat[1]), 32'hFF);
      check("b2b_err0", 32'(got_err[0]), 32'h0);
      check("b2b_err1", 32'(got_err[1]), 32'h0);
      check("b2b_spacing", 32'(got_cyc[1] - got_cyc[0]), 32'd9);
    end

    // Same two frames with random bit_valid gaps
    clear_q();
    for (int i = 0; i < 18; i++) begin
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0, 1'b0);
      tick(b2b_bits[i], 1'b1, 1'b0);
    end
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    chk_busy = 1'b0;
    check("gap_pulses", 32'(got_dat.size()), 32'd2);
    if (got_dat.size() == 2) begin
      check("gap_word0", 32'(got_dat[0]), 32'h3C);
      check("gap_word1", 32'(got_dat[1]), 32'hFF);
      check("gap_err_any", 32'(got_err[0] | got_err[1]), 32'h0);
    end

    // sync_clr after 4 data bits, with a discarded bit, then a full 0x5A
    clear_q();
    repeat (4) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("clr_busy", 32'(ev_if.busy), 32'h0);
    send_word(8'h5A, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    check("clr_pulses", 32'(got_dat.size()), 32'd1);
    check("clr_data_out", 32'(ev_if.data_out), 32'h5A);
    if (got_err.size() == 1) check("clr_err", 32'(got_err[0]), 32'h0);

    // sync_clr coinciding with the parity bit suppresses the completion
    clear_q();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    check("clr_par_pulses", 32'(got_dat.size()), 32'd0);
    check("clr_par_data_hold", 32'(ev_if.data_out), 32'h5A);
    check("clr_par_busy", 32'(ev_if.busy), 32'h0);

    // Asynchronous reset after 5 data bits
    clear_q();
    repeat (5) tick(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("arst_busy_before", 32'(ev_if.busy), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 32'(ev_if.busy), 32'h0);
    check("arst_data_out", 32'(ev_if.data_out), 32'h0);
    check("arst_dv", 32'(ev_if.data_valid), 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    pos = 0;
    exp_busy = 1'b0;
    rst = 1'b0;
    repeat (12) tick(1'b0, 1'b0, 1'b0);
    check("arst_no_pulse", 32'(got_dat.size()), 32'd0);

`ifdef PARITY_CHK_ERR_CNT_EN
    // Error counter saturation, and immunity to good frames
    check("sat_start", 32'(ev_if.err_cnt), 32'd0);
    for (int i = 0; i < 300; i++) send_word(8'h00, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    check("sat_255", 32'(ev_if.err_cnt), 32'd255);
    send_word(8'h00, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    check("sat_good_frame", 32'(ev_if.err_cnt), 32'd255);
    tick(1'b1, 1'b1, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    check("sat_sync_clr", 32'(ev_if.err_cnt), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
